// File: rtl/gray_counter_n_if.sv
// gray_counter_n_if: control and result bundle for the gray_counter_n counter.
//
// Signal semantics (no handshake; every signal is sampled or updated on each
// rising clock edge):
//   master drives En/Up/Load/Load_Value and must hold them stable across the
//   rising edge; slave returns Output/Binary/Overflow, all registered and
//   updated one edge after the controls that caused them.
interface gray_counter_n_if #(
  parameter int WIDTH = 3
);
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] Load_Value;
  logic [WIDTH-1:0] Output;
  logic [WIDTH-1:0] Binary;
  logic             Overflow;

  modport master (
    output En, Up, Load, Load_Value,
    input  Output, Binary, Overflow
  );

  modport slave (
    input  En, Up, Load, Load_Value,
    output Output, Binary, Overflow
  );
endinterface

// File: rtl/gray_counter_n.sv
// gray_counter_n: parametrised up/down Gray-code counter with synchronous load.
// The count is kept in binary; the Gray output is registered from the next
// binary value so it never passes through a combinational decode and flips
// exactly one bit per enabled step.
//
// Build option: define GRAY_SATURATE_EN to make the counter stop at its
// terminal values (Overflow becomes a level while pushing past a terminal)
// instead of wrapping (Overflow is a one-cycle pulse on each wrap).
module gray_counter_n #(
  parameter int          WIDTH    = 3,
  parameter int unsigned INIT_BIN = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  gray_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] INIT_B  = INIT_BIN[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_G  = INIT_B ^ (INIT_B >> 1);
  localparam logic [WIDTH-1:0] MAX_BIN = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             ovf_q;

  logic [WIDTH-1:0] bin_next;
  logic             ovf_next;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next-state selection: load beats count enable, which beats hold.
  always_comb begin
    bin_next = bin_q;
    ovf_next = 1'b0;
    if (bus.Load) begin
      bin_next = gray2bin(bus.Load_Value);
    end else if (bus.En) begin
      if (bus.Up) begin
        if (bin_q == MAX_BIN) begin
          ovf_next = 1'b1;
`ifdef GRAY_SATURATE_EN
          bin_next = bin_q;
`else
          bin_next = ZERO;
`endif
        end else begin
          bin_next = bin_q + ONE;
        end
      end else begin
        if (bin_q == ZERO) begin
          ovf_next = 1'b1;
`ifdef GRAY_SATURATE_EN
          bin_next = bin_q;
`else
          bin_next = MAX_BIN;
`endif
        end else begin
          bin_next = bin_q - ONE;
        end
      end
    end
  end

  // State, Gray output and flag registers; reset takes effect without a clock.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bin_q  <= INIT_B;
      gray_q <= INIT_G;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= bin_next ^ (bin_next >> 1);
      ovf_q  <= ovf_next;
    end
  end

  assign bus.Output   = gray_q;
  assign bus.Binary   = bin_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb_gray_counter_n: directed bench for gray_counter_n at WIDTH=3, INIT_BIN=0.
module tb_gray_counter_n;

  localparam int W = 3;

  logic Clk = 1'b0;
  logic Reset;

  int checks = 0;
  int errors = 0;

  // Hand-written 3-bit Gray sequence indexed by binary count.
  logic [W-1:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                 3'b110, 3'b111, 3'b101, 3'b100};

  gray_counter_n_if #(.WIDTH(W)) bus ();

  gray_counter_n #(.WIDTH(W), .INIT_BIN(0)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock and reset
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.En = 1'b0;
    bus.Up = 1'b1;
    bus.Load = 1'b0;
    bus.Load_Value = '0;
    #3;
    checks++;
    if (bus.Output !== 3'b000) begin
      errors++; $display("FAIL reset_output: got %b expected 000", bus.Output);
    end
    checks++;
    if (bus.Binary !== 3'd0) begin
      errors++; $display("FAIL reset_binary: got %0d expected 0", bus.Binary);
    end
    checks++;
    if (bus.Overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b expected 0", bus.Overflow);
    end
    tick();
    tick();
    Reset = 1'b1;
    tick();
    checks++;
    if (bus.Output !== 3'b000 || bus.Binary !== 3'd0 || bus.Overflow !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_reset: got %b/%0d/%b expected 000/0/0",
               bus.Output, bus.Binary, bus.Overflow);
    end
  endtask

  task automatic test_count_up();
    logic [W-1:0] prev;
    int exp;
    prev = 3'b000;
    bus.En = 1'b1;
    bus.Up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = (i + 1) % 8;
      checks++;
      if (bus.Output !== gray_tab[exp]) begin
        errors++; $display("FAIL up_output step %0d: got %b expected %b", i, bus.Output, gray_tab[exp]);
      end
      checks++;
      if (bus.Binary !== exp[W-1:0]) begin
        errors++; $display("FAIL up_binary step %0d: got %0d expected %0d", i, bus.Binary, exp);
      end
      checks++;
      if (bus.Overflow !== (i == 7)) begin
        errors++; $display("FAIL up_overflow step %0d: got %b expected %b", i, bus.Overflow, (i == 7));
      end
      checks++;
      if ($countones(prev ^ bus.Output) != 1) begin
        errors++; $display("FAIL up_one_bit step %0d: got %b after %b expected one bit change", i, bus.Output, prev);
      end
      prev = bus.Output;
    end
  endtask

`ifndef GRAY_SATURATE_EN
  task automatic test_count_down_wrap();
    bus.En = 1'b1;
    bus.Up = 1'b0;
    tick();
    checks++;
    if (bus.Output !== 3'b100 || bus.Binary !== 3'd7 || bus.Overflow !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: got %b/%0d/%b expected 100/7/1", bus.Output, bus.Binary, bus.Overflow);
    end
    tick();
    checks++;
    if (bus.Output !== 3'b101 || bus.Binary !== 3'd6 || bus.Overflow !== 1'b0) begin
      errors++;
      $display("FAIL down_after_wrap: got %b/%0d/%b expected 101/6/0", bus.Output, bus.Binary, bus.Overflow);
    end
  endtask
`endif

  task automatic test_load();
    bus.Load = 1'b1;
    bus.Load_Value = 3'b110;
    bus.En = 1'b1;
    bus.Up = 1'b0;
    tick();
    checks++;
    if (bus.Output !== 3'b110 || bus.Binary !== 3'd4 || bus.Overflow !== 1'b0) begin
      errors++;
      $display("FAIL load_wins: got %b/%0d/%b expected 110/4/0", bus.Output, bus.Binary, bus.Overflow);
    end
    bus.Load = 1'b0;
    bus.Up = 1'b1;
    tick();
    checks++;
    if (bus.Output !== 3'b111 || bus.Binary !== 3'd5) begin
      errors++;
      $display("FAIL load_then_up: got %b/%0d expected 111/5", bus.Output, bus.Binary);
    end
  endtask

  task automatic test_async_reset();
    bus.Load = 1'b1;
    bus.Load_Value = 3'b000;
    tick();
    bus.Load = 1'b0;
    bus.En = 1'b1;
    bus.Up = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus.Output !== 3'b010) begin
      errors++; $display("FAIL pre_reset_count: got %b expected 010", bus.Output);
    end
    #3;
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.Output !== 3'b000 || bus.Binary !== 3'd0 || bus.Overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %b/%0d/%b expected 000/0/0", bus.Output, bus.Binary, bus.Overflow);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.Output !== 3'b000 || bus.Binary !== 3'd0 || bus.Overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_held cycle %0d: got %b/%0d/%b expected 000/0/0",
                 i, bus.Output, bus.Binary, bus.Overflow);
      end
    end
    #2;
    Reset = 1'b1;
    tick();
    checks++;
    if (bus.Output !== 3'b001 || bus.Binary !== 3'd1) begin
      errors++; $display("FAIL first_step_after_reset: got %b/%0d expected 001/1", bus.Output, bus.Binary);
    end
  endtask

  task automatic test_enable_toggle();
    logic [W-1:0] exp_bin;
    logic         exp_ovf;
    exp_bin = 3'd1;
    bus.Up = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.En = ((c / 5) % 2 == 0);
      tick();
      exp_ovf = 1'b0;
      if (bus.En) begin
        if (exp_bin == 3'd7) begin
          exp_ovf = 1'b1;
`ifdef GRAY_SATURATE_EN
          exp_bin = 3'd7;
`else
          exp_bin = 3'd0;
`endif
        end else begin
          exp_bin = exp_bin + 3'd1;
        end
      end
      checks++;
      if (bus.Output !== gray_tab[exp_bin] || bus.Binary !== exp_bin || bus.Overflow !== exp_ovf) begin
        errors++;
        $display("FAIL enable_toggle cycle %0d: got %b/%0d/%b expected %b/%0d/%b",
                 c, bus.Output, bus.Binary, bus.Overflow, gray_tab[exp_bin], exp_bin, exp_ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]   dirs;
    logic [W-1:0] exp_bin;
    dirs = 6'b011001;
    bus.Load = 1'b1;
    bus.Load_Value = 3'b010;
    tick();
    bus.Load = 1'b0;
    bus.En = 1'b1;
    exp_bin = 3'd3;
    for (int i = 0; i < 6; i++) begin
      bus.Up = dirs[i];
      tick();
      exp_bin = dirs[i] ? exp_bin + 3'd1 : exp_bin - 3'd1;
      checks++;
      if (bus.Output !== gray_tab[exp_bin] || bus.Binary !== exp_bin || bus.Overflow !== 1'b0) begin
        errors++;
        $display("FAIL reversal step %0d: got %b/%0d/%b expected %b/%0d/0",
                 i, bus.Output, bus.Binary, bus.Overflow, gray_tab[exp_bin], exp_bin);
      end
    end
  endtask

`ifdef GRAY_SATURATE_EN
  task automatic test_saturate();
    bus.Load = 1'b1;
    bus.Load_Value = 3'b000;
    tick();
    bus.Load = 1'b0;
    bus.En = 1'b1;
    bus.Up = 1'b1;
    repeat (7) tick();
    checks++;
    if (bus.Output !== 3'b100 || bus.Overflow !== 1'b0) begin
      errors++; $display("FAIL sat_reach_top: got %b/%b expected 100/0", bus.Output, bus.Overflow);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.Output !== 3'b100 || bus.Binary !== 3'd7 || bus.Overflow !== 1'b1) begin
        errors++;
        $display("FAIL sat_hold cycle %0d: got %b/%0d/%b expected 100/7/1", i, bus.Output, bus.Binary, bus.Overflow);
      end
    end
    bus.Up = 1'b0;
    tick();
    checks++;
    if (bus.Output !== 3'b101 || bus.Overflow !== 1'b0) begin
      errors++; $display("FAIL sat_reverse: got %b/%b expected 101/0", bus.Output, bus.Overflow);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
`ifndef GRAY_SATURATE_EN
    test_count_down_wrap();
`endif
    test_load();
    test_async_reset();
    test_enable_toggle();
    test_back_to_back();
`ifdef GRAY_SATURATE_EN
    test_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
- Parametrised Gray-code counter. Successor to the fixed 3-bit gray block.
- Generalised in width, with up/down counting, synchronous parallel load and an explicit binary view of the count.
- Used as a pointer/sequence source, e.g. as a FIFO pointer crossing clock domains.
- Output is registered and changes exactly one bit per enabled step.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16.
- INIT_BIN, 0, binary count value loaded on reset. Output resets to its Gray equivalent.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset: 0 resets immediately; release is taken synchronously to Clk.
- En  input  1  count enable; one step per Clk edge while 1.
- Up  input  1  direction: 1 counts up, 0 counts down. Sampled only when En=1.
- Load  input  1  synchronous load strobe; higher priority than En.
- Load_Value  input  WIDTH  value to load, in Gray code.
- Output  output  WIDTH  current count, Gray code, registered.
- Binary  output  WIDTH  current count, binary, registered, always consistent with Output.
- Overflow  output  1  one-cycle wrap/terminal flag (see Behaviour).

Behaviour:
- State: binary register bin[WIDTH-1:0].
  - Output register holds bin_next ^ (bin_next >> 1), so Output is glitch-free (no combinational decode).
- Reset=0, asynchronous, no clock required:
  - bin = INIT_BIN; Binary = INIT_BIN; Output = gray(INIT_BIN); Overflow = 0.
- Per rising Clk edge with Reset=1, priority Load > En > hold:
  - Load=1: bin <= gray2bin(Load_Value) (prefix XOR from MSB); Output <= Load_Value; Overflow <= 0. En and Up are ignored.
  - Load=0, En=1, Up=1: bin <= bin+1, modulo 2^WIDTH.
  - Load=0, En=1, Up=0: bin <= bin-1, modulo 2^WIDTH.
  - Load=0, En=0: hold all state; Overflow <= 0.
- Latency: one cycle. The Output/Binary change is visible after the edge that sampled En/Load.
- Wrap:
  - Up step from bin = 2^WIDTH-1 to 0, or down step from bin = 0 to 2^WIDTH-1, sets Overflow <= 1 for exactly that one cycle.
  - The flag is registered in the same cycle as the wrapped Output value.
  - All other steps set Overflow <= 0.
- Every enabled step changes exactly one bit of Output, including across the wrap.
- Direction may change on any cycle. A reversal steps back to the previous code; there are no extra cycles and no skipped codes.
- Reset asserted mid-count overrides everything immediately. The counter resumes from INIT_BIN on the first edge after release.
- Load_Value is not range-checked: all 2^WIDTH codes are legal.

Optional Feature:
- Macro: GRAY_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping. An up step at bin = 2^WIDTH-1, or a down step at bin = 0, holds the count.
  - Overflow is a level that stays 1 while the counter sits at a terminal and En=1 pushes further in that direction.
  - Overflow clears on the first cycle that is not such a push: En=0, direction reversed, Load, or Reset.
- Not defined: wrap behaviour as above.
- The reset value and load behaviour are identical in both builds.

Test Plan:
- WIDTH=3, release Reset, En=1, Up=1 for 8 cycles
  -> Output sequence 000,001,011,010,110,111,101,100,000.
  -> Binary 0..7,0.
  -> Overflow=1 only in the cycle Output returns to 000.
  -> Exactly one bit changes per step.
- From Output=000, En=1, Up=0 for 1 cycle
  -> Output=100, Binary=7, Overflow=1.
  -> Next down step: Output=101, Overflow=0.
- Load=1 with Load_Value=110 and En=1, Up=0 in the same cycle
  -> Output=110, Binary=4 (load wins).
  -> Then Up=1 step: Output=111, Binary=5.
- Count to Output=010, drop Reset to 0 between clock edges
  -> Output=000, Binary=0, Overflow=0 before the next Clk edge.
  -> Hold reset for 3 cycles: outputs stay at reset values.
  -> After release, first En step gives 001.
- En toggling every 5 cycles with Up=1
  -> count advances only on cycles with En=1 and holds otherwise.
  -> Overflow=0 during hold cycles.
- GRAY_SATURATE_EN defined, WIDTH=3, count up to 100 and keep En=1, Up=1 for 3 more cycles
  -> Output stays 100, Overflow=1 for all 3 cycles.
  -> Set Up=0: Output=101, Overflow=0.
